// File: rtl/sdspi_ll_byte.sv
// SPI byte engine for the SD-card path: mode-0 MSB-first shifter with chip-select
// setup/hold sequencing and a programmable SCK half-period divider.
module sdspi_ll_byte #(
  parameter int SPDBITS      = 8,
  parameter int OPT_CS_DELAY = 1
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic [SPDBITS-1:0] i_cfg_spd,
  input  logic               i_cs,
  input  logic               i_stb,
  input  logic [7:0]         i_byte,
  output logic               o_busy,
  output logic               o_stb,
  output logic [7:0]         o_byte,
  output logic               o_sck,
  output logic               o_cs_n,
  output logic               o_mosi,
  input  logic               i_miso
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CS_SETUP,
    S_SHIFT,
    S_CS_HOLD
  } state_t;

  localparam logic [3:0] CS_LAST = 4'(OPT_CS_DELAY - 1);

  state_t             state;
  logic [SPDBITS-1:0] spd_r;
  logic [SPDBITS-1:0] div;
  logic [3:0]         cnt;
  logic [7:0]         tx_sr;
  logic [7:0]         rx_sr;
  logic               tick;
  logic               accept;

  assign tick   = (div == '0);
  assign accept = (state == S_IDLE) && i_stb && !o_busy && i_cs;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state  <= S_IDLE;
      o_busy <= 1'b0;
      o_stb  <= 1'b0;
      o_byte <= '1;
      o_sck  <= 1'b0;
      o_cs_n <= 1'b1;
      o_mosi <= 1'b1;
      div    <= '0;
      spd_r  <= '0;
      cnt    <= '0;
      tx_sr  <= '1;
      rx_sr  <= '1;
    end else begin
      o_stb <= 1'b0;
      // Divider free-runs in every active state, reloading on each tick.
      if (state != S_IDLE)
        div <= tick ? spd_r : div - SPDBITS'(1);

      case (state)
        S_IDLE: begin
          if (accept) begin
            spd_r  <= i_cfg_spd;
            div    <= i_cfg_spd;
            cnt    <= '0;
            tx_sr  <= i_byte;
            o_busy <= 1'b1;
            if (o_cs_n) begin
              o_cs_n <= 1'b0;
              state  <= S_CS_SETUP;
            end else begin
              o_mosi <= i_byte[7];
              state  <= S_SHIFT;
            end
          end else if (!i_cs && !o_cs_n) begin
            div    <= spd_r;
            cnt    <= '0;
            o_busy <= 1'b1;
            state  <= S_CS_HOLD;
          end
        end

        S_CS_SETUP: begin
          if (tick) begin
            if (cnt == CS_LAST) begin
              cnt    <= '0;
              o_mosi <= tx_sr[7];
              state  <= S_SHIFT;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end

        S_SHIFT: begin
          // Even cnt -> rising edge (sample), odd cnt -> falling edge (next bit).
          if (tick) begin
            cnt <= cnt + 4'd1;
            if (!cnt[0]) begin
              o_sck <= 1'b1;
              rx_sr <= {rx_sr[6:0], i_miso};
            end else begin
              o_sck <= 1'b0;
              if (cnt == 4'd15) begin
                o_mosi <= 1'b1;
                o_stb  <= 1'b1;
                o_byte <= rx_sr;
                o_busy <= 1'b0;
                state  <= S_IDLE;
              end else begin
                o_mosi <= tx_sr[6];
                tx_sr  <= {tx_sr[6:0], 1'b1};
              end
            end
          end
        end

        S_CS_HOLD: begin
          if (tick) begin
            if (cnt == CS_LAST) begin
              cnt    <= '0;
              o_cs_n <= 1'b1;
              o_busy <= 1'b0;
              state  <= S_IDLE;
            end else begin
              cnt <= cnt + 4'd1;
            end
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdspi_ll_byte.sv
// Scoreboard bench for sdspi_ll_byte: expectations queued at acceptance, checked on o_stb.
module tb_sdspi_ll_byte;

  localparam int SPDBITS = 8;
  localparam int CSD     = 1;

  logic               clk;
  logic               i_reset_n;
  logic [SPDBITS-1:0] i_cfg_spd;
  logic               i_cs;
  logic               i_stb;
  logic [7:0]         i_byte;
  logic               o_busy;
  logic               o_stb;
  logic [7:0]         o_byte;
  logic               o_sck;
  logic               o_cs_n;
  logic               o_mosi;
  logic               i_miso;

  logic miso_loop;
  logic miso_val;
  assign i_miso = miso_loop ? o_mosi : miso_val;

  sdspi_ll_byte #(
    .SPDBITS     (SPDBITS),
    .OPT_CS_DELAY(CSD)
  ) dut (
    .i_clk    (clk),
    .i_reset_n(i_reset_n),
    .i_cfg_spd(i_cfg_spd),
    .i_cs     (i_cs),
    .i_stb    (i_stb),
    .i_byte   (i_byte),
    .o_busy   (o_busy),
    .o_stb    (o_stb),
    .o_byte   (o_byte),
    .o_sck    (o_sck),
    .o_cs_n   (o_cs_n),
    .o_mosi   (o_mosi),
    .i_miso   (i_miso)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [7:0]  tx;
    logic [7:0]  rx;
    int unsigned acc;
    int unsigned lat;
    int unsigned spd;
    bit          chained;
  } exp_t;

  exp_t        sb[$];
  int unsigned total = 0;
  int unsigned bad   = 0;
  int unsigned cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  logic acc_evt = 1'b0;
  always @(posedge clk) acc_evt <= i_reset_n && i_stb && !o_busy && i_cs;

  int unsigned rises = 0, first_rise = 0, last_rise = 0, prev_stb = 0;
  int unsigned sck_cs_bad = 0, cs_hi_stream = 0, mosi_low = 0;
  logic [7:0]  mosi_cap = '0;
  logic        prev_sck = 1'b0;
  bit          in_stream = 1'b0;
  bit          mosi_watch = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (acc_evt) begin
      rises    = 0;
      mosi_cap = '0;
    end
    if (o_sck && !prev_sck) begin
      if (rises == 0) first_rise = cyc;
      last_rise = cyc;
      rises++;
      mosi_cap = {mosi_cap[6:0], o_mosi};
    end
    prev_sck = o_sck;
    if (o_sck && o_cs_n) sck_cs_bad++;
    if (in_stream && o_cs_n) cs_hi_stream++;
    if (mosi_watch && !o_mosi) mosi_low++;
    if (o_stb) begin
      if (sb.size() == 0) begin
        check("unexpected_stb", 1, 0);
      end else begin
        e = sb.pop_front();
        check("rx_byte", o_byte, e.rx);
        check("latency", cyc - e.acc, e.lat);
        check("sck_rises", rises, 8);
        check("mosi_bits", mosi_cap, e.tx);
        check("sck_span", last_rise - first_rise, 14 * (e.spd + 1));
        if (e.chained) check("b2b_accept", e.acc, prev_stb + 1);
      end
      prev_stb = cyc;
    end
  end

  task automatic send(input logic [7:0] b, input logic [7:0] spd, input bit fresh,
                      input bit chained, input bit hold_stb);
    int unsigned n = 0;
    exp_t e;
    i_cfg_spd = spd;
    i_byte    = b;
    i_cs      = 1'b1;
    i_stb     = 1'b1;
    while (o_busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (o_busy) begin
      check("accept_timeout", o_busy, 0);
      i_stb = 1'b0;
      return;
    end
    e.tx      = b;
    e.rx      = miso_loop ? b : {8{miso_val}};
    e.acc     = cyc + 1;
    e.lat     = (16 + (fresh ? CSD : 0)) * (int'(spd) + 1);
    e.spd     = spd;
    e.chained = chained;
    sb.push_back(e);
    @(negedge clk);
    if (!hold_stb) i_stb = 1'b0;
  endtask

  task automatic wait_stb();
    int unsigned n = 0;
    while (!o_stb && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check("stb_timeout", o_stb, 1);
  endtask

  task automatic release_cs(input int unsigned exp_busy);
    int unsigned n = 0, nb = 0, nsck = 0;
    i_cs  = 1'b0;
    i_stb = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (o_busy) nb++;
      if (o_sck) nsck++;
    end while (!o_cs_n && n < 200);
    check("cs_release", o_cs_n, 1);
    check("hold_busy_cycles", nb, exp_busy);
    check("hold_sck_low", nsck, 0);
    check("hold_busy_end", o_busy, 0);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_stb"}, o_stb, 0);
    check({tag, "_sck"}, o_sck, 0);
    check({tag, "_cs_n"}, o_cs_n, 1);
    check({tag, "_mosi"}, o_mosi, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  logic [7:0] stream [6];

  initial begin
    int unsigned nbusy, ncs;
    stream = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h95};
    i_reset_n = 1'b0;
    i_cfg_spd = '0;
    i_cs      = 1'b0;
    i_stb     = 1'b0;
    i_byte    = '0;
    miso_loop = 1'b1;
    miso_val  = 1'b1;

    repeat (3) @(negedge clk);
    check_idle("reset");
    check("reset_byte", o_byte, 8'hff);
    i_reset_n = 1'b1;
    @(negedge clk);

    // Loopback, fastest clock, fresh CS.
    send(8'h40, 8'd0, 1'b1, 1'b0, 1'b0);
    check("cs_fall_after_accept", o_cs_n, 0);
    check("busy_after_accept", o_busy, 1);
    wait_stb();
    release_cs(CSD * 1);

    // MISO held low, MOSI must stay high for an all-ones byte.
    miso_loop  = 1'b0;
    miso_val   = 1'b0;
    mosi_low   = 0;
    mosi_watch = 1'b1;
    send(8'hff, 8'd3, 1'b1, 1'b0, 1'b0);
    i_byte    = 8'h00;
    i_cfg_spd = 8'd0;
    wait_stb();
    mosi_watch = 1'b0;
    check("mosi_high_throughout", mosi_low, 0);
    check("byte_holds", o_byte, 8'h00);
    release_cs(CSD * 4);

    // Back-to-back stream with i_stb held, then CS release.
    miso_loop = 1'b1;
    send(stream[0], 8'd1, 1'b1, 1'b0, 1'b1);
    in_stream    = 1'b1;
    cs_hi_stream = 0;
    for (int i = 1; i < 6; i++)
      send(stream[i], 8'd1, 1'b0, 1'b1, (i != 5));
    wait_stb();
    in_stream = 1'b0;
    check("stream_cs_low", cs_hi_stream, 0);
    check("stream_last_byte", o_byte, 8'h95);
    release_cs(CSD * 2);

    // Request without chip select must be ignored.
    nbusy = 0;
    ncs   = 0;
    i_stb = 1'b1;
    i_cs  = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (o_busy) nbusy++;
      if (!o_cs_n) ncs++;
    end
    i_stb = 1'b0;
    check("nocs_busy", nbusy, 0);
    check("nocs_cs_n", ncs, 0);

    // Reset in the middle of SHIFT aborts without a strobe.
    send(8'ha5, 8'd1, 1'b1, 1'b0, 1'b0);
    repeat (12) @(negedge clk);
    check("pre_reset_busy", o_busy, 1);
    i_reset_n = 1'b0;
    sb.delete();
    @(negedge clk);
    check_idle("midreset");
    check("midreset_byte", o_byte, 8'hff);
    @(negedge clk);
    i_reset_n = 1'b1;
    i_cs      = 1'b1;
    repeat (40) @(negedge clk);
    check_idle("post_reset");

    check("sck_while_cs_high", sck_cs_bad, 0);
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
